// File: rtl/hires_fetch_seq.sv
// Hires 80-column fetch sequencer: per-phi fetch of up to three video RAM bytes inside a cycle window.
// Defining HIRES_FETCH_OVERRUN_EN adds a sticky fetch_overrun output for strobes that arrive mid-sequence.
module hires_fetch_seq #(
  parameter int RAM_WIDTH   = 16,
  parameter int RAM_LATENCY = 2,
  parameter int WIN_START   = 14,
  parameter int WIN_END     = 54,
  parameter int ALTC_BIT    = 7
) (
  input  logic                 clk_dot4x,
  input  logic                 rst,
  input  logic                 clk_phi,
  input  logic [15:0]          phi_phase_start,
  input  logic [6:0]           cycle_num,
  input  logic [2:0]           char_pixel_base,
  input  logic [3:0]           matrix_base,
  input  logic [3:0]           color_base,
  input  logic [2:0]           rc,
  input  logic [10:0]          vc,
  input  logic [14:0]          fvc,
  input  logic                 char_case,
  input  logic [2:0]           hires_mode,
  input  logic [7:0]           video_mem_data,
  output logic [RAM_WIDTH-1:0] video_mem_addr,
  output logic [7:0]           hires_color_data,
  output logic [7:0]           hires_pixel_data,
  output logic [7:0]           hires_pixel_data2,
  output logic                 fetch_valid
`ifdef HIRES_FETCH_OVERRUN_EN
  ,
  output logic                 fetch_overrun
`endif
);

  localparam logic [6:0] WIN_LO   = 7'(WIN_START);
  localparam logic [6:0] WIN_HI   = 7'(WIN_END);
  localparam logic [1:0] LAT_LOAD = 2'(RAM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic [2:0]  mode_q;
  logic [1:0]  slot;
  logic [1:0]  lat_cnt;
  logic [7:0]  color_sh, pix0_sh, pix1_sh;

  logic        win_active, start, capture, capture_last;
  logic [2:0]  issue_mode;
  logic [1:0]  issue_slot, last_slot;
  logic [14:0] issue_addr;
  logic        unused_phase;

  assign unused_phase = ^{phi_phase_start[15:3], phi_phase_start[1:0]};

  always_comb begin
    win_active = ((cycle_num == WIN_LO) && clk_phi)
              || ((cycle_num > WIN_LO) && (cycle_num < WIN_HI))
              || ((cycle_num == WIN_HI) && !clk_phi);
    start = phi_phase_start[2] && win_active && (hires_mode <= 3'd4);
  end

  always_comb begin
    case (mode_q)
      3'b000:                 last_slot = 2'd2;
      3'b001, 3'b010, 3'b011: last_slot = 2'd1;
      default:                last_slot = 2'd0;
    endcase
  end

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ISSUE and WAIT both count down; ISSUE only marks the first slot of a sequence.
  always_comb begin
    state_next   = state;
    capture      = 1'b0;
    capture_last = 1'b0;
    case (state)
      IDLE: if (start) state_next = ISSUE;
      ISSUE, WAIT: begin
        state_next = WAIT;
        if (lat_cnt == 2'd0) begin
          capture = 1'b1;
          if (slot == last_slot) begin
            capture_last = 1'b1;
            state_next   = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The char pointer is used the tick it arrives to form the pixel address, so it needs no register.
  always_comb begin
    issue_mode = (state == IDLE) ? hires_mode : mode_q;
    issue_slot = (state == IDLE) ? 2'd0 : slot + 2'd1;
    issue_addr = {1'b0, fvc[14:1]};
    case (issue_mode)
      3'b000:
        case (issue_slot)
          2'd0:    issue_addr = {color_base, vc};
          2'd1:    issue_addr = {matrix_base, vc};
          default: issue_addr = {char_pixel_base, char_case | color_sh[ALTC_BIT], video_mem_data, rc};
        endcase
      3'b001:         issue_addr = (issue_slot == 2'd0) ? {color_base, vc} : {1'b0, fvc[14:1]};
      3'b010, 3'b011: issue_addr = (issue_slot == 2'd0) ? fvc : (fvc | 15'd1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      mode_q            <= 3'd0;
      slot              <= 2'd0;
      lat_cnt           <= 2'd0;
      color_sh          <= 8'd0;
      pix0_sh           <= 8'd0;
      pix1_sh           <= 8'd0;
      video_mem_addr    <= '0;
      hires_color_data  <= 8'd0;
      hires_pixel_data  <= 8'd0;
      hires_pixel_data2 <= 8'd0;
      fetch_valid       <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mode_q         <= hires_mode;
          slot           <= 2'd0;
          lat_cnt        <= LAT_LOAD;
          video_mem_addr <= RAM_WIDTH'(issue_addr);
          // Seeding from the outputs keeps bytes the mode does not fetch unchanged.
          color_sh       <= hires_color_data;
          pix0_sh        <= hires_pixel_data;
          pix1_sh        <= hires_pixel_data2;
        end
        ISSUE, WAIT: begin
          if (!capture) begin
            lat_cnt <= lat_cnt - 2'd1;
          end else begin
            case (mode_q)
              3'b000: begin
                if (slot == 2'd0)      color_sh <= video_mem_data;
                else if (slot == 2'd2) pix0_sh  <= video_mem_data;
              end
              3'b001: begin
                if (slot == 2'd0) color_sh <= video_mem_data;
                else              pix0_sh  <= video_mem_data;
              end
              3'b010, 3'b011: begin
                if (slot == 2'd0) pix0_sh <= video_mem_data;
                else              pix1_sh <= video_mem_data;
              end
              default: pix0_sh <= video_mem_data;
            endcase
            if (!capture_last) begin
              slot           <= slot + 2'd1;
              lat_cnt        <= LAT_LOAD;
              video_mem_addr <= RAM_WIDTH'(issue_addr);
            end
          end
        end
        DONE: begin
          hires_color_data  <= color_sh;
          hires_pixel_data  <= pix0_sh;
          hires_pixel_data2 <= pix1_sh;
          fetch_valid       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HIRES_FETCH_OVERRUN_EN
  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst)                                                     fetch_overrun <= 1'b0;
    else if (phi_phase_start[2] && win_active && (state != IDLE)) fetch_overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_hires_fetch_seq.sv
// Scoreboard bench for hires_fetch_seq: three instances at RAM latency 2, 3 and 4 share one directed stimulus.
// Each instance has its own pipelined RAM model; monitors check address timing and each fetch_valid pulse.
module tb_hires_fetch_seq;
  localparam int NI = 3;

  typedef struct { int edge_no; logic [15:0] addr; } addr_exp_t;
  typedef struct { int edge_no; logic [7:0] col; logic [7:0] p0; logic [7:0] p1; } out_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_phi = 1'b0;
  logic [15:0] phi_phase_start = 16'd0;
  logic [6:0]  cycle_num = 7'd0;
  logic [2:0]  char_pixel_base = 3'b001;
  logic [3:0]  matrix_base = 4'h3;
  logic [3:0]  color_base = 4'h2;
  logic [2:0]  rc = 3'd3;
  logic [10:0] vc = 11'h005;
  logic [14:0] fvc = 15'h1234;
  logic        char_case = 1'b0;
  logic [2:0]  hires_mode = 3'd0;

  logic [15:0] addr_w  [NI];
  logic [7:0]  ram_w   [NI];
  logic [7:0]  col_w   [NI];
  logic [7:0]  p0_w    [NI];
  logic [7:0]  p1_w    [NI];
  logic        valid_w [NI];
`ifdef HIRES_FETCH_OVERRUN_EN
  logic        ovr_w   [NI];
`endif

  int edge_cnt = 0;
  int checks = 0;
  int errors = 0;
  addr_exp_t aq [NI][$];
  out_exp_t  oq [NI][$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [7:0] ram_read(input logic [15:0] a);
    case (a)
      16'h1005: return 8'h80;
      16'h1805: return 8'h41;
      default:  return a[7:0];
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_lat
    localparam int LAT = gi + 2;
    logic [7:0] pipe [3];

    always @(posedge clk) begin
      pipe[0] <= ram_read(addr_w[gi]);
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign ram_w[gi] = pipe[LAT-2];

    hires_fetch_seq #(.RAM_LATENCY(LAT)) u_dut (
      .clk_dot4x        (clk),
      .rst              (rst),
      .clk_phi          (clk_phi),
      .phi_phase_start  (phi_phase_start),
      .cycle_num        (cycle_num),
      .char_pixel_base  (char_pixel_base),
      .matrix_base      (matrix_base),
      .color_base       (color_base),
      .rc               (rc),
      .vc               (vc),
      .fvc              (fvc),
      .char_case        (char_case),
      .hires_mode       (hires_mode),
      .video_mem_data   (ram_w[gi]),
      .video_mem_addr   (addr_w[gi]),
      .hires_color_data (col_w[gi]),
      .hires_pixel_data (p0_w[gi]),
      .hires_pixel_data2(p1_w[gi]),
      .fetch_valid      (valid_w[gi])
`ifdef HIRES_FETCH_OVERRUN_EN
      ,
      .fetch_overrun    (ovr_w[gi])
`endif
    );

    always @(negedge clk) begin
      addr_exp_t ae;
      out_exp_t  oe;
      if (!rst) begin
        if (aq[gi].size() > 0) begin
          ae = aq[gi][0];
          if (ae.edge_no == edge_cnt) begin
            void'(aq[gi].pop_front());
            chk($sformatf("L%0d addr@%0d", LAT, edge_cnt), addr_w[gi], ae.addr);
          end
        end
        if (valid_w[gi]) begin
          if (oq[gi].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL L%0d unexpected_valid: got 1 at edge %0d expected 0", LAT, edge_cnt);
          end else begin
            oe = oq[gi].pop_front();
            chk($sformatf("L%0d valid_edge", LAT), 16'(edge_cnt), 16'(oe.edge_no));
            chk($sformatf("L%0d colour@%0d", LAT, edge_cnt), {8'd0, col_w[gi]}, {8'd0, oe.col});
            chk($sformatf("L%0d pixel0@%0d", LAT, edge_cnt), {8'd0, p0_w[gi]}, {8'd0, oe.p0});
            chk($sformatf("L%0d pixel1@%0d", LAT, edge_cnt), {8'd0, p1_w[gi]}, {8'd0, oe.p1});
          end
        end
      end
    end
  end

  task automatic check_zero(input string tag, input logic ovr_exp);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s L%0d addr", tag, i + 2), addr_w[i], 16'h0000);
      chk($sformatf("%s L%0d colour", tag, i + 2), {8'd0, col_w[i]}, 16'h0000);
      chk($sformatf("%s L%0d pixel0", tag, i + 2), {8'd0, p0_w[i]}, 16'h0000);
      chk($sformatf("%s L%0d pixel1", tag, i + 2), {8'd0, p1_w[i]}, 16'h0000);
      chk($sformatf("%s L%0d valid", tag, i + 2), {15'd0, valid_w[i]}, 16'h0000);
`ifdef HIRES_FETCH_OVERRUN_EN
      chk($sformatf("%s L%0d overrun", tag, i + 2), {15'd0, ovr_w[i]}, {15'd0, ovr_exp});
`endif
    end
  endtask

  task automatic check_ovr(input logic exp);
`ifdef HIRES_FETCH_OVERRUN_EN
    for (int i = 0; i < NI; i++)
      chk($sformatf("L%0d overrun", i + 2), {15'd0, ovr_w[i]}, {15'd0, exp});
`endif
  endtask

  // One phi period of 16 phase ticks. Address of slot k is expected at edge E+k*L, where E samples
  // phase 2; fetch_valid is expected at edge E+n*L+1. With do_rst, rst is raised at edge E+5.
  task automatic run_phi(input logic [6:0] cyc, input logic phi, input logic [2:0] mode,
                         input logic [6:0] cyc_late, input logic [2:0] mode_late,
                         input bit inject, input bit do_rst, input int nslots,
                         input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                         input logic [7:0] col, input logic [7:0] p0, input logic [7:0] p1);
    logic [15:0] av [3];
    int e;
    av[0] = a0; av[1] = a1; av[2] = a2;
    for (int p = 0; p < 16; p++) begin
      @(negedge clk);
      phi_phase_start = 16'd1 << p;
      if (p == 0) begin
        cycle_num  = cyc;
        clk_phi    = phi;
        hires_mode = mode;
      end
      if (p == 2 && nslots > 0) begin
        e = edge_cnt + 1;
        for (int i = 0; i < NI; i++) begin
          for (int k = 0; k < nslots; k++)
            if (!do_rst || k * (i + 2) <= 5)
              aq[i].push_back(addr_exp_t'{e + k * (i + 2), av[k]});
          if (!do_rst)
            oq[i].push_back(out_exp_t'{e + nslots * (i + 2) + 1, col, p0, p1});
        end
      end
      if (p == 3) begin
        cycle_num  = cyc_late;
        hires_mode = mode_late;
      end
      if (p == 6 && inject) phi_phase_start = 16'd4;
      if (do_rst && p == 8) begin
        rst = 1'b1;
        #1;
        check_zero("midseq_rst", 1'b0);
      end
      if (do_rst && p == 10) rst = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Text mode, colour 0x80 sets ALT so case bit is forced; mode change after start is ignored.
    run_phi(7'd20, 1'b1, 3'd0, 7'd20, 3'd5, 0, 0, 3, 16'h1005, 16'h1805, 16'h1A0B, 8'h80, 8'h0B, 8'h00);
    run_phi(7'd30, 1'b1, 3'd3, 7'd30, 3'd3, 0, 0, 2, 16'h1234, 16'h1235, 16'h0000, 8'h80, 8'h34, 8'h35);
    color_base = 4'h5;
    run_phi(7'd40, 1'b1, 3'd1, 7'd40, 3'd1, 0, 0, 2, 16'h2805, 16'h091A, 16'h0000, 8'h05, 8'h1A, 8'h35);
    run_phi(7'd40, 1'b1, 3'd0, 7'd40, 3'd0, 0, 0, 3, 16'h2805, 16'h1805, 16'h120B, 8'h05, 8'h0B, 8'h35);
    fvc = 15'h7FFF;
    run_phi(7'd45, 1'b1, 3'd4, 7'd45, 3'd4, 0, 0, 1, 16'h3FFF, 16'h0000, 16'h0000, 8'h05, 8'hFF, 8'h35);
    run_phi(7'd20, 1'b1, 3'd5, 7'd20, 3'd5, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00);
    fvc = 15'h0246;
    run_phi(7'd14, 1'b0, 3'd4, 7'd14, 3'd4, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00);
    run_phi(7'd14, 1'b1, 3'd4, 7'd14, 3'd4, 0, 0, 1, 16'h0123, 16'h0000, 16'h0000, 8'h05, 8'h23, 8'h35);
    run_phi(7'd54, 1'b1, 3'd2, 7'd54, 3'd2, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00);
    run_phi(7'd54, 1'b0, 3'd2, 7'd55, 3'd2, 0, 0, 2, 16'h0246, 16'h0247, 16'h0000, 8'h05, 8'h46, 8'h47);
    run_phi(7'd55, 1'b0, 3'd2, 7'd55, 3'd2, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00);
    run_phi(7'd13, 1'b1, 3'd2, 7'd13, 3'd2, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00);
    check_ovr(1'b0);

    // Second phase-2 strobe mid-sequence must not disturb the running sequence.
    color_base = 4'h2;
    run_phi(7'd30, 1'b1, 3'd0, 7'd30, 3'd0, 1, 0, 3, 16'h1005, 16'h1805, 16'h1A0B, 8'h80, 8'h0B, 8'h47);
    check_ovr(1'b1);
    fvc = 15'h1234;
    run_phi(7'd30, 1'b1, 3'd3, 7'd30, 3'd3, 0, 0, 2, 16'h1234, 16'h1235, 16'h0000, 8'h80, 8'h34, 8'h35);
    check_ovr(1'b1);

    run_phi(7'd30, 1'b1, 3'd0, 7'd30, 3'd0, 0, 1, 3, 16'h1005, 16'h1805, 16'h1A0B, 8'h00, 8'h00, 8'h00);
    run_phi(7'd30, 1'b1, 3'd3, 7'd30, 3'd3, 0, 0, 2, 16'h1234, 16'h1235, 16'h0000, 8'h00, 8'h34, 8'h35);

    repeat (20) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("L%0d addr_pending", i + 2), 16'(aq[i].size()), 16'h0000);
      chk($sformatf("L%0d valid_pending", i + 2), 16'(oq[i].size()), 16'h0000);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
